// File: rtl/memout_page_reader.sv
// memout_page_reader
// Reads back the output BRAM page that just finished filling and streams it out.
// The BRAM port-A write port is only observed, to count the entries written per page.
// At each BX boundary the completed page is read through port B into a 4-entry FIFO.
// The FIFO drives a valid/ready stream tagged with the BX of that page.
//
// Handshake: a word transfers in any cycle where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data and out_last stay stable.
// out_valid never drops until its word has transferred, except on a boundary flush.
module memout_page_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int PAGE_AW    = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_proc,
  input  logic [1:0]            bx_in,
  input  logic                  wr_ena,
  input  logic                  wr_wea,
  input  logic [PAGE_AW:0]      wr_addr,
  output logic                  rd_enb,
  output logic [PAGE_AW:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            out_bx,
  output logic                  done,
  output logic                  overflow,
  output logic                  truncated
);

  // Count width holds 0..2^PAGE_AW inclusive, so a full page is distinguishable from empty.
  localparam int CW = PAGE_AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(2 ** PAGE_AW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_n;

  // Boundary tracking
  logic [1:0]          r_bx_q;
  logic                r_primed;
  logic                w_boundary;
  logic                w_start;

  // Write snooping and per-page counts
  logic [CW-1:0]       r_cnt [2];
  logic                w_wr;
  logic                w_wr_page;
  logic [1:0]          w_hit;
  logic [1:0]          w_clr;
  logic                w_sat_wr;
  logic                w_page_clash;
  logic [CW-1:0]       w_cur_len;
  logic                w_unused_ok;

  // Readout context
  logic                r_rd_page;
  logic [CW-1:0]       r_rd_len;
  logic [PAGE_AW-1:0]  r_idx;
  logic [1:0]          r_out_bx;
  logic                r_done;
  logic                r_overflow;
  logic                r_truncated;
  logic                w_issue;
  logic                w_done_n;
  logic                w_trunc_n;
  logic                w_last_idx;

  // Read-latency tracking: one valid/last bit per outstanding BRAM read
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [RD_LATENCY-1:0] r_pipe_last;
  logic [1:0]            w_inflight;
  logic                  w_cap;
  logic                  w_cap_last;
  logic                  w_space;

  // Output FIFO
  logic [DATA_WIDTH-1:0] r_fifo_data [4];
  logic [3:0]            r_fifo_last;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_fifo_cnt;
  logic                  w_fifo_ne;
  logic                  w_pop;
  logic                  w_head_last;

  // Only the page bit of the snooped address matters for counting.
  assign w_unused_ok = &{1'b0, wr_addr[PAGE_AW-1:0]};

  assign w_boundary = en_proc && (bx_in != r_bx_q);
  assign w_start    = w_boundary && r_primed;

  assign w_wr      = wr_ena && wr_wea;
  assign w_wr_page = wr_addr[PAGE_AW];
  assign w_hit     = {w_wr && w_wr_page, w_wr && !w_wr_page};

  // The first boundary after reset clears both pages; later ones clear only the new page.
  assign w_clr = !w_boundary ? 2'b00 :
                 (!r_primed  ? 2'b11 : (bx_in[0] ? 2'b10 : 2'b01));

  assign w_cur_len = r_cnt[r_bx_q[0]];

  // A write to a full page that is not being cleared this cycle cannot be recorded.
  assign w_sat_wr = |(w_hit & ~w_clr & {(r_cnt[1] == CNT_MAX), (r_cnt[0] == CNT_MAX)});

  // Upstream must not write the page under readout; the boundary cycle hands the page back.
  assign w_page_clash = w_wr && (r_state != S_IDLE) && !w_boundary && (w_wr_page == r_rd_page);

  assign w_cap      = r_pipe_vld[RD_LATENCY-1];
  assign w_cap_last = r_pipe_last[RD_LATENCY-1];

  assign w_fifo_ne   = (r_fifo_cnt != 3'd0);
  assign w_pop       = w_fifo_ne && out_ready;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  // Credit check: never have more FIFO words plus outstanding reads than FIFO entries.
  assign w_space    = ({1'b0, r_fifo_cnt} + {2'b00, w_inflight}) < 4'd4;
  assign w_last_idx = ({1'b0, r_idx} == (r_rd_len - CW'(1)));

  // Count outstanding BRAM reads
  always_comb begin
    w_inflight = 2'd0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + {1'b0, r_pipe_vld[i]};
    end
  end

  // Next-state, read issue and pulse decode
  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_done_n  = 1'b0;
    w_trunc_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_n = S_IDLE;
      end
      S_READ: begin
        if (w_space) begin
          w_issue = 1'b1;
          if (w_last_idx) begin
            w_state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    // A primed boundary overrides everything: abandon any page in progress, start the new one.
    if (w_start) begin
      w_issue   = 1'b0;
      w_trunc_n = (r_state != S_IDLE);
      w_done_n  = (w_cur_len == '0);
      w_state_n = (w_cur_len != '0) ? S_READ : S_IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // BX history and priming
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bx_q   <= bx_in;
      r_primed <= 1'b0;
    end else begin
      r_bx_q <= bx_in;
      if (w_boundary) begin
        r_primed <= 1'b1;
      end
    end
  end

  // Per-page entry counters, saturating at a full page
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_clr[p]) begin
          r_cnt[p] <= w_hit[p] ? CW'(1) : '0;
        end else if (w_hit[p] && (r_cnt[p] != CNT_MAX)) begin
          r_cnt[p] <= r_cnt[p] + CW'(1);
        end
      end
    end
  end

  // Readout context captured at each boundary; read index advances per issued read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_page <= 1'b0;
      r_rd_len  <= '0;
      r_out_bx  <= 2'd0;
      r_idx     <= '0;
    end else begin
      if (w_boundary) begin
        r_rd_page <= r_bx_q[0];
        r_rd_len  <= w_cur_len;
        r_out_bx  <= r_bx_q;
      end
      if (w_start) begin
        r_idx <= '0;
      end else if (w_issue) begin
        r_idx <= r_idx + PAGE_AW'(1);
      end
    end
  end

  // Status pulses and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_truncated <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done      <= w_done_n;
      r_truncated <= w_trunc_n;
      if (w_sat_wr || w_page_clash) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Outstanding-read pipeline; a boundary discards every read still in flight
  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset || w_start) begin
        r_pipe_vld  <= '0;
        r_pipe_last <= '0;
      end else begin
        r_pipe_vld[0]  <= w_issue;
        r_pipe_last[0] <= w_issue && w_last_idx;
      end
    end
  end else begin : g_lat2
    always_ff @(posedge clk) begin
      if (reset || w_start) begin
        r_pipe_vld  <= '0;
        r_pipe_last <= '0;
      end else begin
        r_pipe_vld[0]  <= w_issue;
        r_pipe_last[0] <= w_issue && w_last_idx;
        r_pipe_vld[1]  <= r_pipe_vld[0];
        r_pipe_last[1] <= r_pipe_last[0];
      end
    end
  end

  // FIFO pointers, occupancy and last flags; flushed on a boundary
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_fifo_cnt  <= 3'd0;
      r_fifo_last <= 4'd0;
    end else begin
      if (w_cap) begin
        r_fifo_last[r_wr_ptr] <= w_cap_last;
        r_wr_ptr              <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_fifo_cnt <= r_fifo_cnt + {2'b00, w_cap} - {2'b00, w_pop};
    end
  end

  // FIFO data storage captures BRAM data as each read returns
  always_ff @(posedge clk) begin
    if (w_cap && !w_start) begin
      r_fifo_data[r_wr_ptr] <= rd_dout;
    end
  end

  assign rd_enb    = w_issue;
  assign rd_addr   = {r_rd_page, r_idx};
  assign out_valid = w_fifo_ne;
  assign out_data  = w_fifo_ne ? r_fifo_data[r_rd_ptr] : '0;
  assign out_last  = w_fifo_ne && w_head_last;
  assign out_bx    = r_out_bx;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign truncated = r_truncated;

endmodule

// File: tb/tb_memout_page_reader.sv
// Directed bench for memout_page_reader. Two instances share every input:
// dut uses RD_LATENCY=1 and dut2 uses RD_LATENCY=2, each reading its own model BRAM port.
module tb_memout_page_reader;

  localparam int DW = 32;
  localparam int AW = 4;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          en_proc;
  logic [1:0]    bx_in;
  logic          wr_ena;
  logic          wr_wea;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          out_ready;

  logic          rd_enb,  rd_enb2;
  logic [AW:0]   rd_addr, rd_addr2;
  logic [DW-1:0] rd_dout, rd_dout2, rd_stage2;
  logic          out_valid, out_valid2;
  logic [DW-1:0] out_data, out_data2;
  logic          out_last, out_last2;
  logic [1:0]    out_bx, out_bx2;
  logic          done, done2;
  logic          overflow, overflow2;
  logic          truncated, truncated2;

  logic [DW-1:0] bram [32];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  memout_page_reader #(.DATA_WIDTH(DW), .PAGE_AW(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .bx_in(bx_in),
    .wr_ena(wr_ena), .wr_wea(wr_wea), .wr_addr(wr_addr),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_dout(rd_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_bx(out_bx), .done(done),
    .overflow(overflow), .truncated(truncated)
  );

  memout_page_reader #(.DATA_WIDTH(DW), .PAGE_AW(AW), .RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .en_proc(en_proc), .bx_in(bx_in),
    .wr_ena(wr_ena), .wr_wea(wr_wea), .wr_addr(wr_addr),
    .rd_enb(rd_enb2), .rd_addr(rd_addr2), .rd_dout(rd_dout2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_last(out_last2), .out_bx(out_bx2), .done(done2),
    .overflow(overflow2), .truncated(truncated2)
  );

  // Model BRAM: write port A, 1-cycle read for dut, 2-cycle read for dut2
  always @(posedge clk) begin
    if (wr_ena && wr_wea) bram[wr_addr] <= wr_data;
    if (rd_enb) rd_dout <= bram[rd_addr];
    if (rd_enb2) rd_stage2 <= bram[rd_addr2];
    rd_dout2 <= rd_stage2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: n consecutive writes into page pg, index start.., data base+index
  task automatic write_page(input logic pg, input int start, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_ena  = 1'b1;
      wr_wea  = 1'b1;
      wr_addr = {pg, 4'(start + i)};
      wr_data = base + 32'(start + i);
      @(negedge clk);
    end
    wr_ena = 1'b0;
    wr_wea = 1'b0;
  endtask

  // Collect one page from dut against an expected queue, until done or budget runs out
  task automatic stream_check(input string tag, input logic [31:0] base, input int n,
                              input logic [31:0] first_word, input logic [1:0] bx,
                              input bit toggle, output int max_occ, output int issued);
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int got, cyc, acc, occ;
    bit seen_done;
    exp_q.push_back(first_word);
    for (int i = 1; i < n; i++) exp_q.push_back(base + 32'(i));
    got = 0; cyc = 0; acc = 0; issued = 0; max_occ = 0; seen_done = 0;
    while (!seen_done && cyc < 100) begin
      @(negedge clk);
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rd_enb) issued++;
      occ = issued - acc;
      if (occ > max_occ) max_occ = occ;
      if (done) seen_done = 1'b1;
      if (out_valid && out_ready) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({tag, " data"}, out_data, exp_w);
        chk({tag, " last"}, out_last, (got == n - 1));
        chk({tag, " bx"}, out_bx, bx);
        got++;
        acc++;
      end
      cyc++;
    end
    chk({tag, " count"}, got, n);
    chk({tag, " done"}, seen_done, 1'b1);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] B1 = 32'h1111_0000;
  localparam logic [31:0] B2 = 32'h2222_0000;
  localparam logic [31:0] B4 = 32'h4444_0000;
  localparam logic [31:0] B5 = 32'h5555_0000;
  localparam logic [31:0] B6 = 32'h6666_0000;
  localparam logic [31:0] B7 = 32'h7777_0000;
  localparam logic [31:0] B8 = 32'h8888_0000;
  localparam logic [31:0] B9 = 32'h9999_0000;

  initial begin
    int mo, iss;
    bit busy;
    reset = 1'b1; en_proc = 1'b0; bx_in = 2'd2;
    wr_ena = 1'b0; wr_wea = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst overflow", overflow, 1'b0);
    chk("rst truncated", truncated, 1'b0);
    chk("rst rd_enb", rd_enb, 1'b0);
    chk("rst rd_addr", rd_addr, 5'h00);
    chk("rst out_bx", out_bx, 2'd0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst out_last", out_last, 1'b0);
    reset = 1'b0; en_proc = 1'b1;

    // Test 1 (and RD_LATENCY=2 on dut2): prime 2->3, 3 writes to page 1, boundary 3->0
    @(negedge clk); bx_in = 2'd3;
    @(negedge clk);
    chk("prime rd_enb", rd_enb, 1'b0);
    chk("prime done", done, 1'b0);
    write_page(1'b1, 0, 3, B1);
    bx_in = 2'd0;                                   // cycle T
    chk("t1 T valid", out_valid, 1'b0);
    @(negedge clk);                                 // T+1
    chk("t1 T1 rd_enb", rd_enb, 1'b1);
    chk("t1 T1 rd_addr", rd_addr, 5'h10);
    chk("t7 T1 rd_addr", rd_addr2, 5'h10);
    @(negedge clk);                                 // T+2
    chk("t1 T2 rd_addr", rd_addr, 5'h11);
    chk("t1 T2 valid", out_valid, 1'b0);
    @(negedge clk);                                 // T+3
    chk("t1 T3 rd_enb", rd_enb, 1'b1);
    chk("t1 T3 rd_addr", rd_addr, 5'h12);
    chk("t1 T3 valid", out_valid, 1'b1);
    chk("t1 T3 data", out_data, B1);
    chk("t1 T3 last", out_last, 1'b0);
    chk("t1 T3 bx", out_bx, 2'd3);
    chk("t7 T3 valid", out_valid2, 1'b0);
    @(negedge clk);                                 // T+4
    chk("t1 T4 rd_enb", rd_enb, 1'b0);
    chk("t1 T4 data", out_data, B1 + 32'd1);
    chk("t1 T4 last", out_last, 1'b0);
    chk("t7 T4 valid", out_valid2, 1'b1);
    chk("t7 T4 data", out_data2, B1);
    @(negedge clk);                                 // T+5
    chk("t1 T5 data", out_data, B1 + 32'd2);
    chk("t1 T5 last", out_last, 1'b1);
    chk("t1 T5 done", done, 1'b0);
    chk("t7 T5 data", out_data2, B1 + 32'd1);
    @(negedge clk);                                 // T+6
    chk("t1 T6 done", done, 1'b1);
    chk("t1 T6 valid", out_valid, 1'b0);
    chk("t7 T6 data", out_data2, B1 + 32'd2);
    chk("t7 T6 last", out_last2, 1'b1);
    @(negedge clk);                                 // T+7
    chk("t1 T7 done", done, 1'b0);
    chk("t7 T7 done", done2, 1'b1);

    // Test 2: 8 entries on page 0, out_ready alternating
    write_page(1'b0, 0, 8, B2);
    bx_in = 2'd1;
    stream_check("t2", B2, 8, B2, 2'd0, 1'b1, mo, iss);
    chk("t2 max occupancy", mo, 4);
    chk("t2 reads issued", iss, 8);

    // Test 3: empty page 1 -> done at T+1, nothing streamed
    @(negedge clk); bx_in = 2'd2;
    chk("t3 T valid", out_valid, 1'b0);
    @(negedge clk);
    chk("t3 T1 done", done, 1'b1);
    chk("t3 T1 rd_enb", rd_enb, 1'b0);
    chk("t3 T1 truncated", truncated, 1'b0);
    @(negedge clk);
    chk("t3 T2 done", done, 1'b0);
    chk("t3 T2 valid", out_valid, 1'b0);

    // Test 4: 17 writes to page 0 -> saturate at 16, overflow, index 0 holds 17th word
    write_page(1'b0, 0, 16, B4);
    chk("t4 ovf after 16", overflow, 1'b0);
    write_page(1'b0, 16, 1, B4);
    chk("t4 ovf after 17", overflow, 1'b1);
    bx_in = 2'd3;
    stream_check("t4", B4, 16, B4 + 32'd16, 2'd2, 1'b0, mo, iss);
    chk("t4 ovf sticky", overflow, 1'b1);

    // Test 5: 16 entries, out_ready=0, boundary after 5 cycles -> truncate, next page streams
    write_page(1'b1, 0, 16, B5);
    out_ready = 1'b0;
    bx_in = 2'd0;                                   // T
    @(negedge clk);                                 // T+1
    chk("t5 T1 rd_addr", rd_addr, 5'h10);
    wr_ena = 1'b1; wr_wea = 1'b1; wr_addr = 5'h00; wr_data = B6;
    @(negedge clk);                                 // T+2
    wr_addr = 5'h01; wr_data = B6 + 32'd1;
    @(negedge clk);                                 // T+3
    wr_ena = 1'b0; wr_wea = 1'b0;
    @(negedge clk);                                 // T+4
    chk("t5 T4 rd_enb", rd_enb, 1'b1);
    chk("t5 T4 rd_addr", rd_addr, 5'h13);
    chk("t5 T4 data", out_data, B5);
    @(negedge clk);                                 // T+5
    chk("t5 T5 stall", rd_enb, 1'b0);
    chk("t5 T5 valid", out_valid, 1'b1);
    bx_in = 2'd1;
    @(negedge clk);                                 // T+6
    chk("t5 T6 truncated", truncated, 1'b1);
    chk("t5 T6 flushed", out_valid, 1'b0);
    chk("t5 T6 done", done, 1'b0);
    chk("t5 T6 rd_enb", rd_enb, 1'b1);
    chk("t5 T6 rd_addr", rd_addr, 5'h00);
    chk("t5 T6 bx", out_bx, 2'd0);
    out_ready = 1'b1;
    @(negedge clk);                                 // T+7
    chk("t5 T7 truncated", truncated, 1'b0);
    stream_check("t5 next", B6, 2, B6, 2'd0, 1'b0, mo, iss);

    // Test 6: reset mid-readout, then a primed-only boundary, then normal readout
    write_page(1'b1, 0, 4, B7);
    bx_in = 2'd2;
    repeat (3) @(negedge clk);
    chk("t6 pre valid", out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6 rst valid", out_valid, 1'b0);
    chk("t6 rst data", out_data, 32'h0);
    chk("t6 rst last", out_last, 1'b0);
    chk("t6 rst bx", out_bx, 2'd0);
    chk("t6 rst done", done, 1'b0);
    chk("t6 rst overflow", overflow, 1'b0);
    chk("t6 rst truncated", truncated, 1'b0);
    chk("t6 rst rd_enb", rd_enb, 1'b0);
    chk("t6 rst rd_addr", rd_addr, 5'h00);
    reset = 1'b0;
    write_page(1'b0, 0, 3, B8);
    bx_in = 2'd3;
    busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid || rd_enb || done || truncated) busy = 1'b1;
    end
    chk("t6 prime no readout", busy, 1'b0);
    write_page(1'b1, 0, 1, B9);
    bx_in = 2'd0;
    repeat (3) @(negedge clk);
    chk("t6 after valid", out_valid, 1'b1);
    chk("t6 after data", out_data, B9);
    chk("t6 after last", out_last, 1'b1);
    chk("t6 after bx", out_bx, 2'd3);
    @(negedge clk);
    chk("t6 after done", done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
